// File: rtl/dr_pkg.sv
// Shared types and helpers for the dual-rail token transmitter.
package dr_pkg;

  localparam string ENC_TWO_PHASE  = "TWO_PHASE";
  localparam string ENC_FOUR_PHASE = "FOUR_PHASE";

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_HI  = 2'd1,
    WAIT_LO  = 2'd2,
    WAIT_ACK = 2'd3
  } state_t;

  // One bit lane of a return-to-zero data token: {t, f}.
  function automatic logic [1:0] dr_encode(input logic data);
    return {data, ~data};
  endfunction

endpackage

// File: rtl/dr_token_tx_if.sv
// Word handshake, dual-rail output and completion signals of the token transmitter.
interface dr_token_tx_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [W-1:0] dr_t;
  logic [W-1:0] dr_f;
  logic         ack;
  logic         busy;
  logic         err;

  modport master (
    output in_valid, in_data, ack,
    input  in_ready, dr_t, dr_f, busy, err
  );

  modport slave (
    input  in_valid, in_data, ack,
    output in_ready, dr_t, dr_f, busy, err
  );
endinterface

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for the asynchronous completion signal.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_ff: STAGES must be at least 2");
  end

  logic [STAGES-1:0] sh;

  always_ff @(posedge clk) begin
    if (rst) sh <= '0;
    else     sh <= {sh[STAGES-2:0], d};
  end

  assign q = sh[STAGES-1];

endmodule

// File: rtl/dr_token_tx.sv
// Launches clocked words into a dual-rail async pipeline, completing each token
// against the synchronized receiver ack (transition or return-to-zero encoding).
//
// state    | meaning
// IDLE     | no token in flight; in_ready depends on ack_s (and phase_r in 2P)
// WAIT_HI  | 4P: data rails driven, waiting for ack_s rise
// WAIT_LO  | 4P: rails NULL, waiting for ack_s fall
// WAIT_ACK | 2P: rails toggled, waiting for ack_s to match phase_r
module dr_token_tx
  import dr_pkg::*;
#(
  parameter string ENC         = "TWO_PHASE",
  parameter int    W           = 8,
  parameter int    SYNC_STAGES = 2,
  parameter int    TIMEOUT     = 0
) (
  input logic          clk,
  input logic          rst,
  dr_token_tx_if.slave bus
);

  localparam bit IS_4P = (ENC == ENC_FOUR_PHASE);

  if ((ENC != ENC_TWO_PHASE) && (ENC != ENC_FOUR_PHASE)) begin : g_bad_enc
    $error("dr_token_tx: ENC must be TWO_PHASE or FOUR_PHASE");
  end

  state_t       state, state_nxt;
  logic [W-1:0] t_r, f_r, t_nxt, f_nxt;
  logic [W-1:0] t_enc, f_enc;
  logic         phase_r, phase_nxt;
  logic         ack_s;
  logic         rdy;
  logic         err_r;

  sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.ack),
    .q   (ack_s)
  );

  always_comb begin
    t_enc = '0;
    f_enc = '0;
    for (int i = 0; i < W; i++) begin
      {t_enc[i], f_enc[i]} = dr_encode(bus.in_data[i]);
    end
  end

  always_comb begin
    state_nxt = state;
    t_nxt     = t_r;
    f_nxt     = f_r;
    phase_nxt = phase_r;
    rdy       = 1'b0;
    unique case (state)
      IDLE: begin
        rdy = IS_4P ? ~ack_s : (ack_s == phase_r);
        if (bus.in_valid && rdy) begin
          if (IS_4P) begin
            t_nxt     = t_enc;
            f_nxt     = f_enc;
            state_nxt = WAIT_HI;
          end else begin
            // Each bit toggles exactly one of its two rails.
            t_nxt     = t_r ^ bus.in_data;
            f_nxt     = f_r ^ ~bus.in_data;
            phase_nxt = ~phase_r;
            state_nxt = WAIT_ACK;
          end
        end
      end
      WAIT_HI: begin
        if (!IS_4P) begin
          state_nxt = IDLE;
          t_nxt     = '0;
          f_nxt     = '0;
          phase_nxt = 1'b0;
        end else if (ack_s) begin
          t_nxt     = '0;
          f_nxt     = '0;
          state_nxt = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!IS_4P) begin
          state_nxt = IDLE;
          t_nxt     = '0;
          f_nxt     = '0;
          phase_nxt = 1'b0;
        end else if (!ack_s) begin
          state_nxt = IDLE;
        end
      end
      WAIT_ACK: begin
        if (IS_4P) begin
          state_nxt = IDLE;
          t_nxt     = '0;
          f_nxt     = '0;
        end else if (ack_s == phase_r) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        t_nxt     = '0;
        f_nxt     = '0;
        phase_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      t_r     <= '0;
      f_r     <= '0;
      phase_r <= 1'b0;
    end else begin
      state   <= state_nxt;
      t_r     <= t_nxt;
      f_r     <= f_nxt;
      phase_r <= phase_nxt;
    end
  end

  if (TIMEOUT > 0) begin : g_timer
    localparam int           TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] timer;

    // err only flags the stall; the FSM keeps waiting for the ack.
    always_ff @(posedge clk) begin
      if (rst) begin
        timer <= '0;
        err_r <= 1'b0;
      end else begin
        if ((state == IDLE) || (state_nxt != state)) timer <= '0;
        else if (timer != T_LAST)                    timer <= timer + 1'b1;
        if ((state != IDLE) && (timer == T_LAST)) err_r <= 1'b1;
      end
    end
  end else begin : g_no_timer
    assign err_r = 1'b0;
  end

  assign bus.in_ready = rdy;
  assign bus.dr_t     = t_r;
  assign bus.dr_f     = f_r;
  assign bus.busy     = (state != IDLE);
  assign bus.err      = err_r;

endmodule
